move_sequencer: RTL and testbench

MOVE_SEQUENCER -- requirements
Module: move_sequencer

---
 rtl/move_sequencer.sv | 177 +++++++++++++++++
 tb/tb_move_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// move_sequencer: queues 4-bit move codes in a small FIFO and issues them one
// at a time to a stepper executor, handshaking on move_done and enforcing an
// idle gap between moves.
// Optional feature: define MOVE_SEQ_ACK_TIMEOUT_EN to bound the wait for the
// executor to acknowledge a move_start (sets error, flushes, returns to IDLE).
module move_sequencer #(
  parameter int DEPTH       = 16,
  parameter int GAP_CYCLES  = 1000,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] wr_move,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       run,
  input  logic       abort,
  input  logic       move_done,
  output logic [3:0] next_move,
  output logic       move_start,
  output logic       busy,
  output logic [5:0] fifo_count,
  output logic [7:0] moves_executed,
  output logic       error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  // Parameter sanity checks, evaluated at elaboration only.
  if (DEPTH < 4 || DEPTH > 32 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("move_sequencer: DEPTH must be a power of two in 4..32");
  end
  if (GAP_CYCLES < 1 || ACK_TIMEOUT < 1) begin : g_bad_timing
    $error("move_sequencer: GAP_CYCLES and ACK_TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, GAP} state_t;

  state_t           state;
  state_t           state_next;
  logic [3:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [GAP_W-1:0] gap_cnt;
  logic             code_ok;
  logic             wr_fire;
  logic             code_bad;
  logic             fifo_empty;
  logic             pop;
  logic             done_evt;
  logic             timeout_evt;
  logic             flush;

  // Only codes 2..13 are meaningful moves; the rest are rejected at the door.
  assign code_ok    = (wr_move >= 4'd2) && (wr_move <= 4'd13);
  assign wr_ready   = (fifo_count < 6'(DEPTH)) && !abort;
  assign wr_fire    = wr_valid && wr_ready && code_ok;
  assign code_bad   = wr_valid && wr_ready && !code_ok;
  assign fifo_empty = (fifo_count == 6'd0);
  assign flush      = abort || timeout_evt;
  assign busy       = (state != IDLE);

`ifdef MOVE_SEQ_ACK_TIMEOUT_EN
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  logic [ACK_W-1:0] ack_cnt;

  // Count clocks spent waiting for the executor to drop move_done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               ack_cnt <= '0;
    else if (state == WAIT_ACK) ack_cnt <= ack_cnt + 1'b1;
    else                        ack_cnt <= '0;
  end
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic and per-state strobes; abort blocks any new issue.
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    done_evt    = 1'b0;
    timeout_evt = 1'b0;
    case (state)
      IDLE: begin
        if (run && !fifo_empty && move_done && !abort) state_next = ISSUE;
      end
      ISSUE: begin
        pop        = 1'b1;
        state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!move_done) begin
          state_next = WAIT_DONE;
        end
`ifdef MOVE_SEQ_ACK_TIMEOUT_EN
        else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
          timeout_evt = 1'b1;
          state_next  = IDLE;
        end
`endif
      end
      WAIT_DONE: begin
        if (move_done) begin
          done_evt   = 1'b1;
          state_next = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          state_next = (run && !fifo_empty && !abort) ? ISSUE : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clock) begin
    if (wr_fire) mem[wr_ptr] <= wr_move;
  end

  // FIFO pointers and occupancy; a flush overrides any push or pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= 6'd0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= 6'd0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({wr_fire, pop})
        2'b10:   fifo_count <= fifo_count + 6'd1;
        2'b01:   fifo_count <= fifo_count - 6'd1;
        default: ;
      endcase
    end
  end

  // Registered head read; next_move holds until the next issue.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      next_move  <= 4'd0;
      move_start <= 1'b0;
    end else begin
      move_start <= pop;
      if (pop) next_move <= mem[rd_ptr];
    end
  end

  // Gap timer runs only while in GAP.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)          gap_cnt <= '0;
    else if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
    else                   gap_cnt <= '0;
  end

  // Completed-move counter (wraps) and sticky error flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      moves_executed <= 8'd0;
      error          <= 1'b0;
    end else begin
      if (done_evt)                moves_executed <= moves_executed + 8'd1;
      if (code_bad || timeout_evt) error          <= 1'b1;
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Testbench for move_sequencer: scoreboard of expected issued moves checked by
// a monitor on move_start, plus directed status checks.
module tb_move_sequencer;
  localparam int DEPTH       = 16;
  localparam int GAP_CYCLES  = 8;
  localparam int ACK_TIMEOUT = 20;

  logic       clock;
  logic       reset_n;
  logic [3:0] wr_move;
  logic       wr_valid;
  logic       wr_ready;
  logic       run;
  logic       abort;
  logic       move_done;
  logic [3:0] next_move;
  logic       move_start;
  logic       busy;
  logic [5:0] fifo_count;
  logic [7:0] moves_executed;
  logic       error;

  int checks;
  int errors;
  int cyc;
  int starts;
  int last_start;
  int hold_cycles;
  logic exec_en;
  logic [3:0] exp_q[$];

  move_sequencer #(
    .DEPTH(DEPTH),
    .GAP_CYCLES(GAP_CYCLES),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .wr_move(wr_move),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .run(run),
    .abort(abort),
    .move_done(move_done),
    .next_move(next_move),
    .move_start(move_start),
    .busy(busy),
    .fifo_count(fifo_count),
    .moves_executed(moves_executed),
    .error(error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Called at a negedge; presents one write for one cycle.
  task automatic push(input logic [3:0] m);
    wr_move  = m;
    wr_valid = 1'b1;
    @(negedge clock);
    wr_valid = 1'b0;
  endtask

  // Bounded wait for the sequencer to return to IDLE.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clock);
      n++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  // Model executor: drops move_done after a start, holds it low, then raises it.
  initial begin
    move_done = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (move_start && exec_en) begin
        move_done = 1'b0;
        repeat (hold_cycles) @(posedge clock);
        #1 move_done = 1'b1;
      end
    end
  end

  // Scoreboard monitor: every move_start must match the next expected move.
  initial begin
    logic [3:0] exp_move;
    forever begin
      @(negedge clock);
      if (move_start) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL move_start: unexpected start with next_move=%0d, expected none", next_move);
        end else begin
          exp_move = exp_q.pop_front();
          if (next_move !== exp_move) begin
            errors++;
            $display("FAIL next_move: got %0d, expected %0d", next_move, exp_move);
          end else begin
            $display("ok   issue: next_move=%0d at cycle %0d", next_move, cyc);
          end
          if (starts > 0) begin
            checks++;
            if (cyc - last_start < GAP_CYCLES) begin
              errors++;
              $display("FAIL start_spacing: got %0d cycles, expected >= %0d", cyc - last_start, GAP_CYCLES);
            end
          end
          last_start = cyc;
          starts++;
        end
      end
    end
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; starts = 0; last_start = 0;
    hold_cycles = 4; exec_en = 1'b1;
    reset_n = 1'b0; wr_move = 4'd0; wr_valid = 1'b0; run = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset next_move", {28'd0, next_move}, 32'd0);
    chk("reset move_start", {31'd0, move_start}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset fifo_count", {26'd0, fifo_count}, 32'd0);
    chk("reset moves_executed", {24'd0, moves_executed}, 32'd0);
    chk("reset error", {31'd0, error}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("wr_ready after reset", {31'd0, wr_ready}, 32'd1);

    // Three moves with run=1, start latency from an empty FIFO.
    run = 1'b1;
    exp_q.push_back(4'd4);
    push(4'd4);
    chk("start latency +0", {31'd0, move_start}, 32'd0);
    @(negedge clock);
    chk("start latency +1", {31'd0, move_start}, 32'd0);
    @(negedge clock);
    chk("start latency +2", {31'd0, move_start}, 32'd1);
    exp_q.push_back(4'd5);
    push(4'd5);
    exp_q.push_back(4'd2);
    push(4'd2);
    wait_idle("three moves idle");
    chk("three moves executed", {24'd0, moves_executed}, 32'd3);
    chk("three moves starts", starts, 32'd3);

    // Fill with run=0: full at DEPTH, extra write rejected, nothing issued.
    run = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(4'(2 + (i % 12)));
    chk("full fifo_count", {26'd0, fifo_count}, DEPTH);
    chk("full wr_ready", {31'd0, wr_ready}, 32'd0);
    push(4'd7);
    chk("overfill fifo_count", {26'd0, fifo_count}, DEPTH);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort flush idle", {26'd0, fifo_count}, 32'd0);
    chk("no error yet", {31'd0, error}, 32'd0);

    // Illegal codes are not stored and set error.
    push(4'd0);
    push(4'd15);
    chk("illegal fifo_count", {26'd0, fifo_count}, 32'd0);
    chk("illegal error", {31'd0, error}, 32'd1);

    // Abort with a same-cycle write during WAIT_DONE, 5 moves queued.
    run = 1'b1;
    hold_cycles = 20;
    exp_q.push_back(4'd3);
    push(4'd3);
    for (int i = 0; i < 5; i++) push(4'(7 + i));
    chk("queued before abort", {26'd0, fifo_count}, 32'd5);
    chk("busy before abort", {31'd0, busy}, 32'd1);
    abort = 1'b1; wr_move = 4'd12; wr_valid = 1'b1;
    @(negedge clock);
    abort = 1'b0; wr_valid = 1'b0;
    chk("abort fifo_count", {26'd0, fifo_count}, 32'd0);
    wait_idle("abort idle");
    chk("abort moves_executed", {24'd0, moves_executed}, 32'd4);
    chk("abort fifo stays empty", {26'd0, fifo_count}, 32'd0);

    // Asynchronous reset during WAIT_DONE.
    exp_q.push_back(4'd6);
    push(4'd6);
    push(4'd9);
    repeat (4) @(negedge clock);
    chk("pre-reset busy", {31'd0, busy}, 32'd1);
    chk("pre-reset fifo_count", {26'd0, fifo_count}, 32'd1);
    run = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async next_move", {28'd0, next_move}, 32'd0);
    chk("async move_start", {31'd0, move_start}, 32'd0);
    chk("async busy", {31'd0, busy}, 32'd0);
    chk("async fifo_count", {26'd0, fifo_count}, 32'd0);
    chk("async moves_executed", {24'd0, moves_executed}, 32'd0);
    chk("async error", {31'd0, error}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int n = 0; n < 100 && !move_done; n++) @(negedge clock);
    chk("executor released", {31'd0, move_done}, 32'd1);
    @(negedge clock);
    chk("post-reset busy", {31'd0, busy}, 32'd0);
    chk("post-reset wr_ready", {31'd0, wr_ready}, 32'd1);

`ifdef MOVE_SEQ_ACK_TIMEOUT_EN
    // Executor never acknowledges: timeout sets error and flushes.
    exec_en = 1'b0;
    run = 1'b1;
    exp_q.push_back(4'd6);
    push(4'd6);
    push(4'd7);
    repeat (ACK_TIMEOUT) @(negedge clock);
    chk("timeout error before", {31'd0, error}, 32'd0);
    chk("timeout busy before", {31'd0, busy}, 32'd1);
    @(negedge clock);
    chk("timeout error", {31'd0, error}, 32'd1);
    chk("timeout idle", {31'd0, busy}, 32'd0);
    chk("timeout flush", {26'd0, fifo_count}, 32'd0);
    run = 1'b0;
`endif

    repeat (3) @(negedge clock);
    chk("scoreboard drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
